// File: rtl/fir_coeff_load_ctrl.sv
// Coefficient load sequencer for the transposed FIR: routes host writes into four
// coefficient SRAM banks, reads all taps back into the tap registers, then enables the MAC.
module fir_coeff_load_ctrl #(
    parameter int NUM_TAPS   = 33,
    parameter int BANK_DEPTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int DATA_W     = 16
) (
    input  logic                        iClk_12M,
    input  logic                        iRsn,
    input  logic                        iCoeffiUpdateFlag,
    input  logic                        iCsnRam,
    input  logic                        iWrnRam,
    input  logic [5:0]                  iAddrRam,
    input  logic [DATA_W-1:0]           iWrDtRam,
    input  logic [5:0]                  iNumOfCoeff,
    input  logic [NUM_BANKS*DATA_W-1:0] iRdDtRam,
    output logic [NUM_BANKS-1:0]        oCsnRam,
    output logic                        oWrnRam,
    output logic [3:0]                  oAddrRam,
    output logic [DATA_W-1:0]           oWrDtRam,
    output logic                        oCoeffLdEn,
    output logic [5:0]                  oCoeffLdIdx,
    output logic signed [DATA_W-1:0]    oCoeffLdDt,
    output logic [NUM_TAPS-1:0]         oTapEn,
    output logic                        oRun,
    output logic                        oBusy,
    output logic                        oCfgErr
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UPDATE = 3'd1,
        LOAD   = 3'd2,
        DRAIN  = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  ld_cnt;
    logic [5:0]  cnt_lat;
    logic        load_pend;
    logic        host_wr;
    logic        host_idx_ok;
    logic [5:0]  next_cnt;

    function automatic logic [BANK_W-1:0] bank_of(input logic [5:0] idx);
        logic [BANK_W-1:0] b;
        b = '0;
        for (int i = 1; i < NUM_BANKS; i++) begin
            if (int'(idx) >= i * BANK_DEPTH) b = BANK_W'(i);
        end
        return b;
    endfunction

    function automatic logic [3:0] local_addr(input logic [5:0] idx);
        return 4'(int'(idx) - int'(bank_of(idx)) * BANK_DEPTH);
    endfunction

    function automatic logic [NUM_BANKS-1:0] bank_csn(input logic [5:0] idx);
        return ~(NUM_BANKS'(1) << bank_of(idx));
    endfunction

    function automatic logic [5:0] clamp_count(input logic [5:0] n);
        return (int'(n) > NUM_TAPS) ? 6'(NUM_TAPS) : n;
    endfunction

    function automatic logic [NUM_TAPS-1:0] tap_mask(input logic [5:0] cnt);
        logic [NUM_TAPS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            m[i] = (i < int'(cnt));
        end
        return m;
    endfunction

    function automatic logic signed [DATA_W-1:0] bank_word(
        input logic [NUM_BANKS*DATA_W-1:0] rd,
        input logic [BANK_W-1:0]           b
    );
        return rd[int'(b)*DATA_W +: DATA_W];
    endfunction

    assign host_wr     = !iCsnRam && !iWrnRam;
    assign host_idx_ok = int'(iAddrRam) < NUM_TAPS;
    assign next_cnt    = ld_cnt + 6'd1;

    always_ff @(posedge iClk_12M) begin
        if (iRsn) begin
            state       <= IDLE;
            ld_cnt      <= '0;
            cnt_lat     <= '0;
            load_pend   <= 1'b0;
            oCsnRam     <= '1;
            oWrnRam     <= 1'b1;
            oAddrRam    <= '0;
            oWrDtRam    <= '0;
            oCoeffLdEn  <= 1'b0;
            oCoeffLdIdx <= '0;
            oCoeffLdDt  <= '0;
            oTapEn      <= '0;
            oRun        <= 1'b0;
            oBusy       <= 1'b0;
            oCfgErr     <= 1'b0;
        end else begin
            // Strobe and bank access are single-cycle unless re-asserted below.
            oCoeffLdEn <= 1'b0;
            oCsnRam    <= '1;
            oWrnRam    <= 1'b1;

            case (state)
                IDLE: begin
                    oRun <= 1'b0;
                    if (iCoeffiUpdateFlag) begin
                        state     <= UPDATE;
                        oBusy     <= 1'b1;
                        oCfgErr   <= 1'b0;
                        load_pend <= 1'b0;
                    end
                end

                UPDATE: begin
                    if (load_pend) begin
                        // Write that coincided with the flag fall has gone out; start reading now.
                        load_pend <= 1'b0;
                        if (!iCoeffiUpdateFlag) begin
                            state    <= LOAD;
                            ld_cnt   <= '0;
                            oCsnRam  <= bank_csn(6'd0);
                            oAddrRam <= '0;
                        end
                    end else begin
                        if (host_wr && host_idx_ok) begin
                            oCsnRam  <= bank_csn(iAddrRam);
                            oWrnRam  <= 1'b0;
                            oAddrRam <= local_addr(iAddrRam);
                            oWrDtRam <= iWrDtRam;
                        end else if (host_wr) begin
                            oCfgErr <= 1'b1;
                        end

                        if (!iCoeffiUpdateFlag) begin
                            cnt_lat <= clamp_count(iNumOfCoeff);
                            if (host_wr && host_idx_ok) begin
                                load_pend <= 1'b1;
                            end else begin
                                state    <= LOAD;
                                ld_cnt   <= '0;
                                oCsnRam  <= bank_csn(6'd0);
                                oAddrRam <= '0;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (iCoeffiUpdateFlag) begin
                        state     <= UPDATE;
                        oBusy     <= 1'b1;
                        oCfgErr   <= 1'b0;
                        oRun      <= 1'b0;
                        load_pend <= 1'b0;
                    end else begin
                        // Read data for ld_cnt is valid now; capture it as this tap's strobe.
                        oCoeffLdEn  <= 1'b1;
                        oCoeffLdIdx <= ld_cnt;
                        oCoeffLdDt  <= bank_word(iRdDtRam, bank_of(ld_cnt));
                        if (ld_cnt == 6'(NUM_TAPS - 1)) begin
                            state <= DRAIN;
                        end else begin
                            ld_cnt   <= next_cnt;
                            oCsnRam  <= bank_csn(next_cnt);
                            oAddrRam <= local_addr(next_cnt);
                        end
                    end
                end

                DRAIN: begin
                    if (iCoeffiUpdateFlag) begin
                        state     <= UPDATE;
                        oBusy     <= 1'b1;
                        oCfgErr   <= 1'b0;
                        oRun      <= 1'b0;
                        load_pend <= 1'b0;
                    end else begin
                        state  <= RUN;
                        oRun   <= 1'b1;
                        oBusy  <= 1'b0;
                        oTapEn <= tap_mask(cnt_lat);
                    end
                end

                RUN: begin
                    if (iCoeffiUpdateFlag) begin
                        state     <= UPDATE;
                        oBusy     <= 1'b1;
                        oCfgErr   <= 1'b0;
                        oRun      <= 1'b0;
                        load_pend <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    oRun  <= 1'b0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Directed bench for fir_coeff_load_ctrl with a small behavioural model of the four
// coefficient SRAM banks (write on clock edge, read data follows the address).
module tb_fir_coeff_load_ctrl;

    logic        clk = 1'b0;
    logic        rsn;
    logic        flag;
    logic        csn_h;
    logic        wrn_h;
    logic [5:0]  addr_h;
    logic [15:0] wrdt_h;
    logic [5:0]  num_coeff;
    logic [63:0] rd_dt;
    logic [3:0]  csn_ram;
    logic        wrn_ram;
    logic [3:0]  addr_ram;
    logic [15:0] wrdt_ram;
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [15:0] ld_dt;
    logic [32:0] tap_en;
    logic        run;
    logic        busy;
    logic        cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [4][10];
    logic [15:0] exp_coef [33];
    logic [32:0] last_tapen;

    localparam logic [32:0] ALL_TAPS = 33'h1_FFFF_FFFF;

    typedef struct {
        logic [5:0]  num;
        logic [32:0] tapen;
    } tv_t;

    tv_t tv [6];

    always #5 clk = ~clk;

    fir_coeff_load_ctrl dut (
        .iClk_12M          (clk),
        .iRsn              (rsn),
        .iCoeffiUpdateFlag (flag),
        .iCsnRam           (csn_h),
        .iWrnRam           (wrn_h),
        .iAddrRam          (addr_h),
        .iWrDtRam          (wrdt_h),
        .iNumOfCoeff       (num_coeff),
        .iRdDtRam          (rd_dt),
        .oCsnRam           (csn_ram),
        .oWrnRam           (wrn_ram),
        .oAddrRam          (addr_ram),
        .oWrDtRam          (wrdt_ram),
        .oCoeffLdEn        (ld_en),
        .oCoeffLdIdx       (ld_idx),
        .oCoeffLdDt        (ld_dt),
        .oTapEn            (tap_en),
        .oRun              (run),
        .oBusy             (busy),
        .oCfgErr           (cfg_err)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!csn_ram[b] && !wrn_ram && addr_ram < 4'd10) mem[b][addr_ram] <= wrdt_ram;
        end
    end

    always_comb begin
        rd_dt = '0;
        for (int b = 0; b < 4; b++) begin
            if (addr_ram < 4'd10) rd_dt[b*16 +: 16] = mem[b][addr_ram];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_csn(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (idx / 10));
    endfunction

    task automatic check_reset_vals();
        chk("rst_csn",    64'(csn_ram),  64'(4'hF));
        chk("rst_wrn",    64'(wrn_ram),  64'(1'b1));
        chk("rst_addr",   64'(addr_ram), 64'(0));
        chk("rst_wrdt",   64'(wrdt_ram), 64'(0));
        chk("rst_ld_en",  64'(ld_en),    64'(0));
        chk("rst_ld_idx", 64'(ld_idx),   64'(0));
        chk("rst_ld_dt",  64'(ld_dt),    64'(0));
        chk("rst_tapen",  64'(tap_en),   64'(0));
        chk("rst_run",    64'(run),      64'(0));
        chk("rst_busy",   64'(busy),     64'(0));
        chk("rst_cfgerr", 64'(cfg_err),  64'(0));
    endtask

    // Host write issued in UPDATE; checks the bank access visible in the following cycle.
    task automatic host_write(input int idx, input logic [15:0] val);
        csn_h  = 1'b0;
        wrn_h  = 1'b0;
        addr_h = 6'(idx);
        wrdt_h = val;
        tick();
        csn_h = 1'b1;
        wrn_h = 1'b1;
        if (idx < 33) begin
            exp_coef[idx] = val;
            chk("wr_csn",  64'(csn_ram),  64'(exp_csn(idx)));
            chk("wr_addr", 64'(addr_ram), 64'(idx % 10));
            chk("wr_wrn",  64'(wrn_ram),  64'(1'b0));
            chk("wr_data", 64'(wrdt_ram), 64'(val));
        end else begin
            chk("badwr_csn", 64'(csn_ram), 64'(4'hF));
            chk("badwr_wrn", 64'(wrn_ram), 64'(1'b1));
            chk("badwr_err", 64'(cfg_err), 64'(1'b1));
        end
    endtask

    // Called in LOAD cycle 0; follows the full readback and the switch into RUN.
    task automatic run_load(input logic [32:0] tapen);
        chk("ld0_csn",  64'(csn_ram),  64'(4'b1110));
        chk("ld0_addr", 64'(addr_ram), 64'(0));
        chk("ld0_wrn",  64'(wrn_ram),  64'(1'b1));
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c <= 33) begin
                chk("strobe_en",  64'(ld_en),  64'(1'b1));
                chk("strobe_idx", 64'(ld_idx), 64'(c - 1));
                chk("strobe_dt",  64'(ld_dt),  64'(exp_coef[c-1]));
                chk("load_run",   64'(run),    64'(1'b0));
                if (c <= 32) begin
                    chk("rd_csn",  64'(csn_ram),  64'(exp_csn(c)));
                    chk("rd_addr", 64'(addr_ram), 64'(c % 10));
                    chk("rd_wrn",  64'(wrn_ram),  64'(1'b1));
                end else begin
                    chk("drain_csn", 64'(csn_ram), 64'(4'hF));
                end
            end else begin
                chk("run_ld_en", 64'(ld_en),  64'(1'b0));
                chk("run_on",    64'(run),    64'(1'b1));
                chk("run_busy",  64'(busy),   64'(1'b0));
                chk("run_tapen", 64'(tap_en), 64'(tapen));
            end
        end
        last_tapen = tapen;
    endtask

    initial begin
        tv[0] = '{num: 6'd5,  tapen: 33'h0_0000_001F};
        tv[1] = '{num: 6'd40, tapen: ALL_TAPS};
        tv[2] = '{num: 6'd0,  tapen: 33'h0};
        tv[3] = '{num: 6'd1,  tapen: 33'h0_0000_0001};
        tv[4] = '{num: 6'd12, tapen: 33'h0_0000_0FFF};
        tv[5] = '{num: 6'd32, tapen: 33'h0_FFFF_FFFF};

        rsn       = 1'b1;
        flag      = 1'b0;
        csn_h     = 1'b1;
        wrn_h     = 1'b1;
        addr_h    = '0;
        wrdt_h    = '0;
        num_coeff = 6'd33;
        last_tapen = '0;

        // Reset and idle behaviour
        tick();
        tick();
        check_reset_vals();
        rsn = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_run",  64'(run),  64'(0));

        // Full update of all taps followed by a complete load
        flag = 1'b1;
        tick();
        chk("upd_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 33; i++) host_write(i, 16'(100 + i));
        flag = 1'b0;
        tick();
        run_load(ALL_TAPS);

        // Negative coefficient in bank 2
        flag = 1'b1;
        tick();
        host_write(23, 16'hFFF6);
        tick();
        chk("wr23_release_csn", 64'(csn_ram), 64'(4'hF));
        chk("wr23_release_wrn", 64'(wrn_ram), 64'(1'b1));
        flag = 1'b0;
        tick();
        run_load(ALL_TAPS);
        chk("coef23_signed", 64'($signed(exp_coef[23]) == -16'sd10), 64'(1));

        // Tap-enable mask for a table of latched counts
        for (int t = 0; t < 6; t++) begin
            flag = 1'b1;
            tick();
            num_coeff = tv[t].num;
            flag = 1'b0;
            tick();
            num_coeff = 6'd7;
            run_load(tv[t].tapen);
        end

        // Out-of-range write sets a sticky error
        num_coeff = 6'd33;
        flag = 1'b1;
        tick();
        chk("err_clear_on_entry", 64'(cfg_err), 64'(0));
        host_write(40, 16'h1234);
        flag = 1'b0;
        tick();
        chk("err_in_load", 64'(cfg_err), 64'(1));
        run_load(ALL_TAPS);
        chk("err_in_run", 64'(cfg_err), 64'(1));
        flag = 1'b1;
        tick();
        chk("err_cleared", 64'(cfg_err), 64'(0));
        chk("reupd_run",   64'(run),     64'(0));
        chk("reupd_busy",  64'(busy),    64'(1));

        // Host write coinciding with the flag fall delays LOAD by one cycle
        csn_h  = 1'b0;
        wrn_h  = 1'b0;
        addr_h = 6'd5;
        wrdt_h = 16'h1234;
        flag   = 1'b0;
        tick();
        csn_h = 1'b1;
        wrn_h = 1'b1;
        exp_coef[5] = 16'h1234;
        chk("simul_csn",   64'(csn_ram),  64'(4'b1110));
        chk("simul_addr",  64'(addr_ram), 64'(5));
        chk("simul_wrn",   64'(wrn_ram),  64'(0));
        chk("simul_ld_en", 64'(ld_en),    64'(0));
        tick();
        run_load(ALL_TAPS);

        // Abort in the middle of LOAD, then a full reload
        flag = 1'b1;
        tick();
        num_coeff = 6'd20;
        flag = 1'b0;
        tick();
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("abort_pre_en",  64'(ld_en),  64'(1));
            chk("abort_pre_idx", 64'(ld_idx), 64'(c - 1));
        end
        flag = 1'b1;
        tick();
        chk("abort_ld_en", 64'(ld_en),  64'(0));
        chk("abort_busy",  64'(busy),   64'(1));
        chk("abort_run",   64'(run),    64'(0));
        chk("abort_tapen", 64'(tap_en), 64'(last_tapen));
        chk("abort_csn",   64'(csn_ram), 64'(4'hF));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_quiet", 64'(ld_en), 64'(0));
        end
        flag = 1'b0;
        tick();
        run_load(33'h0_000F_FFFF);

        // Reset in the middle of LOAD
        flag = 1'b1;
        tick();
        flag = 1'b0;
        tick();
        for (int c = 1; c <= 5; c++) tick();
        chk("prerst_idx", 64'(ld_idx), 64'(4));
        rsn = 1'b1;
        tick();
        check_reset_vals();
        rsn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_ld_en", 64'(ld_en),   64'(0));
            chk("postrst_csn",   64'(csn_ram), 64'(4'hF));
            chk("postrst_busy",  64'(busy),    64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
